// File: rtl/apb3_pkg.sv
// Shared types for the APB3 step initiator: FSM states, default widths and
// the command/response records at those default widths.
package apb3_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } apb_cmd_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] rdata;
        logic                  err;
    } apb_rsp_t;

endpackage

// File: rtl/apb3_cmd_fifo.sv
// Synchronous command FIFO. Pointers carry one extra wrap bit so that
// full and empty are told apart without a separate counter.
module apb3_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 65
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic         push_en, pop_en;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;
    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_en) wptr_d = wptr_q + (AW+1)'(1);
        if (pop_en)  rptr_d = rptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/apb3_step_initiator.sv
// APB3 initiator: drains queued commands one at a time through SETUP/ACCESS
// and holds each response until consumed. APB_TIMEOUT_EN adds an ACCESS wait limit.
module apb3_step_initiator
    import apb3_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              PCLK,
    input  logic              PRESERN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);
    localparam int CMD_W = 1 + ADDR_W + DATA_W;

    apb_state_e        state_q, state_d;
    logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;

    logic              fifo_full, fifo_empty, fifo_pop, tmo_hit;
    logic [CMD_W-1:0]  fifo_din, fifo_dout;

    assign fifo_din = {cmd_write, cmd_addr, cmd_wdata};
    assign fifo_pop = (state_q == IDLE) && !fifo_empty;

    apb3_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(CMD_W)) u_fifo (
        .clk_i   (PCLK),
        .rst_i   (PRESERN),
        .push_i  (cmd_valid),
        .pop_i   (fifo_pop),
        .din_i   (fifo_din),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q;

    // Hit on the last allowed wait cycle, so the abort edge ends wait cycle TIMEOUT_CYC.
    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge PCLK) begin
        if (PRESERN)                          tmo_q <= '0;
        else if (state_q == SETUP)            tmo_q <= '0;
        else if (state_q == ACCESS && !PREADY) tmo_q <= tmo_q + TMO_W'(1);
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESERN) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (PREADY || tmo_hit) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    {pwrite_d, paddr_d, pwdata_d} = fifo_dout;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                end
            end
            SETUP: penable_d = 1'b1;
            ACCESS: begin
                // PREADY takes priority over an abort in the same cycle.
                if (PREADY) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                end else if (tmo_hit) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end
            end
            RESP: if (rsp_ready) rsp_valid_d = 1'b0;
            default: ;
        endcase
    end

    assign cmd_ready = !fifo_full;
    assign busy      = !fifo_empty || (state_q != IDLE);
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb3_step_initiator.sv
// Directed bench for apb3_step_initiator; inputs change 1 time unit after
// each rising edge and outputs are sampled there too.
module tb_apb3_step_initiator;

    logic        PCLK = 1'b0;
    logic        PRESERN, cmd_valid, cmd_write, rsp_ready, PREADY, PSLVERR;
    logic [31:0] cmd_addr, cmd_wdata, PRDATA;
    logic        cmd_ready, rsp_valid, rsp_err, busy, PSEL, PENABLE, PWRITE;
    logic [31:0] rsp_rdata, PADDR, PWDATA;

    int vectors = 0;
    int miscompares = 0;

    always #5 PCLK = ~PCLK;

    apb3_step_initiator #(
        .ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4), .TIMEOUT_CYC(8)
    ) dut (
        .PCLK(PCLK), .PRESERN(PRESERN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_setup(input string tag, input logic [31:0] exp_addr, input logic [31:0] exp_data);
        logic seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (PSEL && !PENABLE) seen = 1'b1;
        end
        check({tag, "_seen"}, 64'(seen), 64'd1);
        if (seen) check({tag, "_addr_data"}, {PADDR, PWDATA}, {exp_addr, exp_data});
    endtask

    task automatic wait_rsp(input string tag, input logic [31:0] exp_rdata, input logic exp_err);
        logic seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (rsp_valid) seen = 1'b1;
        end
        check({tag, "_seen"}, 64'(seen), 64'd1);
        if (seen) check({tag, "_rsp"}, {rsp_err, rsp_rdata}, {exp_err, exp_rdata});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        PRESERN = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1; PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'hDEAD_BEEF;
        step(); step();
        PRESERN = 1'b0;
        check("rst_apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 67'd0);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata, busy}, 35'd0);
        check("rst_ready", 64'(cmd_ready), 64'd1);

        // Single write: PRDATA is non-zero but must not leak into rsp_rdata.
        push(1'b1, 32'h4, 32'h5);
        check("wr_k0", {PSEL, busy}, 2'b01);
        step();
        check("wr_setup", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b101, 32'h4, 32'h5});
        step();
        check("wr_access", {PSEL, PENABLE}, 2'b11);
        step();
        check("wr_rsp", {PSEL, PENABLE, rsp_valid, rsp_err, rsp_rdata}, {4'b0010, 32'h0});
        step();
        check("wr_done", {rsp_valid, busy, PWRITE, PADDR}, {3'b001, 32'h4});

        // Read with three wait states.
        PREADY = 1'b0; PRDATA = 32'h0;
        push(1'b0, 32'h0, 32'h77);
        step();
        check("rd_setup", {PSEL, PENABLE, PWRITE, PADDR}, {3'b100, 32'h0});
        step();
        check("rd_access", {PSEL, PENABLE}, 2'b11);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rd_hold", {PSEL, PENABLE, PWRITE, rsp_valid, PADDR, PWDATA},
                  {4'b1100, 32'h0, 32'h77});
        end
        PREADY = 1'b1; PRDATA = 32'h1;
        step();
        check("rd_rsp", {PSEL, PENABLE, rsp_valid, rsp_err, rsp_rdata}, {4'b0010, 32'h1});
        step();
        check("rd_done", {rsp_valid, busy}, 2'b00);

        // Backpressure: 4 queued + 1 in flight fill the initiator.
        rsp_ready = 1'b0; PRDATA = 32'h0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_write = 1'b1;
            cmd_addr = 32'h10 + 32'(4 * i); cmd_wdata = 32'(i);
            step();
            check("full_ready", 64'(cmd_ready), (i < 4) ? 64'd1 : 64'd0);
        end
        check("full_rsp_held", {rsp_valid, rsp_err, rsp_rdata, PADDR}, {2'b10, 32'h0, 32'h10});
        cmd_addr = 32'h24; cmd_wdata = 32'd5;
        step(); step();
        check("full_blocked", {cmd_ready, rsp_valid}, 2'b01);
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        wait_setup("order1", 32'h14, 32'd1);
        wait_setup("order2", 32'h18, 32'd2);
        wait_setup("order3", 32'h1C, 32'd3);
        wait_setup("order4", 32'h20, 32'd4);
        repeat (8) step();
        check("full_drained", {busy, PSEL, cmd_ready, PADDR}, {3'b001, 32'h20});

        // Slave error, then a clean transfer.
        PSLVERR = 1'b1; PRDATA = 32'hABCD;
        push(1'b0, 32'h8, 32'h0);
        wait_rsp("err1", 32'hABCD, 1'b1);
        PSLVERR = 1'b0; PRDATA = 32'h55;
        push(1'b0, 32'hC, 32'h0);
        wait_rsp("err2", 32'h55, 1'b0);
        repeat (3) step();

        // Reset while ACCESS is stalled with two commands still queued.
        PREADY = 1'b0;
        push(1'b1, 32'h30, 32'h1);
        push(1'b1, 32'h34, 32'h2);
        push(1'b1, 32'h38, 32'h3);
        check("mid_access", {PSEL, PENABLE, busy, PADDR}, {3'b111, 32'h30});
        PRESERN = 1'b1;
        step();
        PRESERN = 1'b0; PREADY = 1'b1;
        check("mid_rst", {PSEL, PENABLE, busy, cmd_ready, rsp_valid, PADDR}, {5'b00010, 32'h0});
        repeat (5) step();
        check("mid_discard", {PSEL, busy, rsp_valid}, 3'b000);

`ifdef APB_TIMEOUT_EN
        // PREADY stuck low: abort after 8 ACCESS cycles.
        PREADY = 1'b0; PRDATA = 32'hFF;
        push(1'b0, 32'h40, 32'h0);
        step(); step();
        repeat (7) step();
        check("tmo_wait", {PSEL, PENABLE, rsp_valid}, 3'b110);
        step();
        check("tmo_abort", {PSEL, PENABLE, rsp_valid, rsp_err, rsp_rdata}, {4'b0011, 32'h0});
        step();
        check("tmo_done", {rsp_valid, busy}, 2'b00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
